// File: rtl/accumulator_drain.sv
// accumulator_drain
// Read-side sequencer for the accumulator. A start command reads N consecutive
// rows from base_addr_i and streams them to a valid/ready consumer through a
// 2-entry skid FIFO, so one row per cycle is sustained while the consumer is ready.
// ReLU, when latched at start, is applied to each row as it is captured.
module accumulator_drain #(
    parameter int LANES      = 32,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 7,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [ADDR_W-1:0]         base_addr_i,
    input  logic [7:0]                num_rows_i,
    input  logic                      diag_mode_i,
    input  logic                      relu_i,
    output logic                      acc_rd_en_o,
    output logic [ADDR_W-1:0]         acc_addr_rd_o,
    output logic                      acc_rd_mode_o,
    output logic                      acc_add_o,
    input  logic [LANES*DATA_W-1:0]   acc_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [LANES*DATA_W-1:0]   out_data_o,
    output logic                      out_last_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int         ROW_W    = LANES * DATA_W;
    localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Clamp every negative signed word of a row to zero when enabled.
    function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] row,
                                                  input logic             en);
        logic [ROW_W-1:0] res;
        res = row;
        for (int i = 0; i < LANES; i++) begin
            if (en && row[i*DATA_W + DATA_W - 1]) begin
                res[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else begin
                res[i*DATA_W +: DATA_W] = row[i*DATA_W +: DATA_W];
            end
        end
        return res;
    endfunction

    state_t            r_state;
    state_t            w_next_state;
    logic              w_issue;
    logic              w_pop;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_rows_left;
    logic              r_mode;
    logic              r_relu;
    logic [ROW_W-1:0]  r_mem [2];
    logic [1:0]        r_last;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    assign w_pop = (r_count != 2'd0) && out_ready_i;

    // Next-state and read-issue decision; a read goes out only when a FIFO slot is free or frees up this cycle.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next_state = S_READ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_READ: begin
                if ((r_rows_left != 8'd0) && ((r_count < FULL_CNT) || w_pop)) begin
                    w_issue = 1'b1;
                end else begin
                    w_issue = 1'b0;
                end
                if (w_issue && (r_rows_left == 8'd1)) begin
                    w_next_state = S_FLUSH;
                end else begin
                    w_next_state = S_READ;
                end
            end
            S_FLUSH: begin
                if (r_count == 2'd0) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_FLUSH;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register plus command latching and the read address / row counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_addr      <= {ADDR_W{1'b0}};
            r_rows_left <= 8'd0;
            r_mode      <= 1'b0;
            r_relu      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && start_i) begin
                r_addr      <= base_addr_i;
                r_rows_left <= (num_rows_i == 8'd0) ? 8'd128 : num_rows_i;
                r_mode      <= diag_mode_i;
                r_relu      <= relu_i;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_rows_left <= r_rows_left - 8'd1;
            end
        end
    end

    // Two-entry skid FIFO: the row read this cycle is captured at the issuing edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem[0] <= {ROW_W{1'b0}};
            r_mem[1] <= {ROW_W{1'b0}};
            r_last   <= 2'b00;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_issue) begin
                r_mem[r_wr_ptr]  <= relu_row(acc_data_i, r_relu);
                r_last[r_wr_ptr] <= (r_rows_left == 8'd1);
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_issue} - {1'b0, w_pop};
        end
    end

    assign acc_rd_en_o   = w_issue;
    assign acc_addr_rd_o = r_addr;
    assign acc_rd_mode_o = r_mode;
    assign acc_add_o     = 1'b0;
    assign out_valid_o   = (r_count != 2'd0);
    assign out_data_o    = r_mem[r_rd_ptr];
    assign out_last_o    = r_last[r_rd_ptr];
    assign busy_o        = (r_state == S_READ) || (r_state == S_FLUSH);
    assign done_o        = (r_state == S_DONE);

endmodule

// File: tb/tb_accumulator_drain.sv
// Testbench for accumulator_drain: a behavioural accumulator memory feeds the
// DUT, and a count-based reference model (rows issued / rows popped) predicts
// read strobes, addresses, output rows, last flags, busy and done each cycle.
module tb_accumulator_drain;

    localparam int LANES  = 32;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;
    localparam int ROW_W  = LANES * DATA_W;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [7:0]        num_rows_i;
    logic              diag_mode_i;
    logic              relu_i;
    logic              acc_rd_en_o;
    logic [ADDR_W-1:0] acc_addr_rd_o;
    logic              acc_rd_mode_o;
    logic              acc_add_o;
    logic [ROW_W-1:0]  acc_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [ROW_W-1:0]  out_data_o;
    logic              out_last_o;
    logic              busy_o;
    logic              done_o;

    logic [ROW_W-1:0]  mem [128];
    int                total = 0;
    int                bad   = 0;

    accumulator_drain #(
        .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .base_addr_i(base_addr_i), .num_rows_i(num_rows_i),
        .diag_mode_i(diag_mode_i), .relu_i(relu_i),
        .acc_rd_en_o(acc_rd_en_o), .acc_addr_rd_o(acc_addr_rd_o),
        .acc_rd_mode_o(acc_rd_mode_o), .acc_add_o(acc_add_o),
        .acc_data_i(acc_data_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    // Accumulator read port: combinational, same-cycle data.
    assign acc_data_i = mem[acc_addr_rd_o];

    function automatic logic [ROW_W-1:0] ref_relu(input logic [ROW_W-1:0] row, input bit en);
        logic [ROW_W-1:0] r;
        logic [31:0]      w;
        r = row;
        if (en) begin
            for (int l = 0; l < LANES; l++) begin
                w = row[l*DATA_W +: DATA_W];
                if ($signed(w) < 0) r[l*DATA_W +: DATA_W] = 32'd0;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        int lane;
        total++;
        assert (obs === exp) else begin
            bad++;
            lane = 0;
            for (int l = LANES - 1; l >= 0; l--)
                if (obs[l*DATA_W +: DATA_W] !== exp[l*DATA_W +: DATA_W]) lane = l;
            $error("FAIL %s lane %0d: observed=%h expected=%h", tag, lane,
                   obs[lane*DATA_W +: DATA_W], exp[lane*DATA_W +: DATA_W]);
        end
    endtask

    // ready_mode: 0 = always ready, 1 = random, 2 = low for 10 cycles then high.
    task automatic run_cmd(input int base, input int n, input bit diag, input bit relu,
                           input int ready_mode, input bit spam);
        logic [ROW_W-1:0] exp_q[$];
        int  nr, issued, popped, occ, last_pop;
        bit  pop_m, exp_rd, finished;
        nr = (n == 0) ? 128 : n;
        issued = 0; popped = 0; occ = 0; last_pop = -1; finished = 1'b0;
        for (int i = 0; i < nr; i++) exp_q.push_back(ref_relu(mem[(base + i) % 128], relu));

        @(negedge clk_i);
        base_addr_i = 7'(base); num_rows_i = 8'(n);
        diag_mode_i = diag; relu_i = relu; start_i = 1'b1; out_ready_i = 1'b0;
        #1;
        chk("idle_busy", busy_o, 0);
        chk("idle_rd_en", acc_rd_en_o, 0);

        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk_i);
            start_i = spam && (last_pop < 0 || cyc < last_pop + 3);
            if (spam) begin
                base_addr_i = 7'($urandom); num_rows_i = 8'($urandom);
                diag_mode_i = ~diag; relu_i = ~relu;
            end
            case (ready_mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = ($urandom_range(0, 3) != 0);
                default: out_ready_i = (cyc > 10);
            endcase
            #1;
            pop_m  = (occ > 0) && out_ready_i;
            exp_rd = (issued < nr) && (occ < 2 || pop_m);
            chk("out_valid", out_valid_o, (occ > 0));
            chk("rd_en", acc_rd_en_o, exp_rd);
            chk("acc_add", acc_add_o, 0);
            if (exp_rd) chk("rd_addr", acc_addr_rd_o, 64'((base + issued) % 128));
            chk("rd_mode", acc_rd_mode_o, diag);
            chk("busy", busy_o, (last_pop < 0 || cyc <= last_pop + 1));
            chk("done", done_o, (last_pop >= 0 && cyc == last_pop + 2));
            if (pop_m) begin
                chk_row("out_data", out_data_o, exp_q[popped]);
                chk("out_last", out_last_o, (popped == nr - 1));
            end
            if (exp_rd) begin issued++; occ++; end
            if (pop_m) begin
                popped++; occ--;
                if (popped == nr) last_pop = cyc;
            end
            if (last_pop >= 0 && cyc == last_pop + 3) begin
                finished = 1'b1;
                break;
            end
        end
        start_i = 1'b0;
        chk("cmd_completes", finished, 1);
    endtask

    initial begin
        logic [ROW_W-1:0] row;
        rst_ni = 1'b0; start_i = 1'b0; base_addr_i = '0; num_rows_i = 8'd0;
        diag_mode_i = 1'b0; relu_i = 1'b0; out_ready_i = 1'b0;
        for (int r = 0; r < 128; r++)
            for (int l = 0; l < LANES; l++) mem[r][l*DATA_W +: DATA_W] = $urandom;

        // Reset state
        #2;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_rd_en", acc_rd_en_o, 0);
        chk("rst_addr", acc_addr_rd_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_mode", acc_rd_mode_o, 0);
        chk_row("rst_data", out_data_o, '0);
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;

        // Basic command, full rate
        run_cmd(5, 4, 1'b0, 1'b0, 0, 1'b0);
        // Address wrap 127 -> 0
        run_cmd(126, 4, 1'b0, 1'b0, 0, 1'b0);
        // Consumer stalls for 10 cycles
        run_cmd(10, 3, 1'b0, 1'b0, 2, 1'b0);
        // ReLU on mixed-sign words
        for (int l = 0; l < LANES; l++)
            row[l*DATA_W +: DATA_W] = (l % 2 == 0) ? 32'hFFFF_FFF0 : 32'h0000_0010;
        mem[40] = row;
        run_cmd(40, 2, 1'b0, 1'b1, 0, 1'b0);
        // Diagonal mode with start strobes while busy
        run_cmd(60, 6, 1'b1, 1'b0, 1, 1'b1);
        // Random commands, random backpressure
        for (int k = 0; k < 4; k++)
            run_cmd(int'($urandom_range(0, 127)), int'($urandom_range(1, 20)),
                    1'($urandom), 1'($urandom), 1, 1'($urandom));
        // num_rows = 0 means 128 rows
        run_cmd(100, 0, 1'b0, 1'b1, 0, 1'b0);

        // Reset during a stall with two rows buffered
        @(negedge clk_i);
        base_addr_i = 7'd5; num_rows_i = 8'd3; diag_mode_i = 1'b1; relu_i = 1'b0;
        start_i = 1'b1; out_ready_i = 1'b0;
        @(negedge clk_i); start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("stall_rd_en", acc_rd_en_o, 0);
        chk("stall_valid", out_valid_o, 1);
        chk("stall_mode", acc_rd_mode_o, 1);
        chk("stall_busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid_o, 0);
        chk("mid_rst_rd_en", acc_rd_en_o, 0);
        chk("mid_rst_addr", acc_addr_rd_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_mode", acc_rd_mode_o, 0);
        chk("mid_rst_last", out_last_o, 0);
        chk_row("mid_rst_data", out_data_o, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_cmd(5, 4, 1'b0, 1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
